// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the DataMemory port arbiter.
package dm_port_arbiter_pkg;

  localparam int unsigned DM_DATA_W   = 64;
  localparam int unsigned DM_MEM_SIZE = 1024;
  localparam int unsigned DM_MEM_BITS = 10;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_ISSUE = 2'd1,
    DMA_RESP  = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// Two-way round-robin pick with the registered priority pointer.
module dm_port_arbiter_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       open_i,
  output logic       gnt_vld_o,
  output logic       winner_o
);

  logic prio_q, prio_d;

  always_comb begin
    winner_o  = req_i[1];
    gnt_vld_o = open_i & (|req_i);
    prio_d    = prio_q;
    if (req_i == 2'b11) winner_o = prio_q;
    // the pointer moves on every grant, errored transactions included
    if (gnt_vld_o) prio_d = ~winner_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one DataMemory port between a CPU load/store requester and a debug/DMA loader,
// one registered transaction at a time: grant G, memory strobes G+1, response G+2.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DM_DATA_W,
  parameter int unsigned MEM_SIZE = DM_MEM_SIZE,
  parameter int unsigned MEM_BITS = DM_MEM_BITS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              r0_req_i,
  input  logic              r0_we_i,
  input  logic [DATA_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  input  logic              r1_req_i,
  input  logic              r1_we_i,
  input  logic [DATA_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_rsp_vld_o,
  output logic              r0_rsp_err_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  output logic              r1_gnt_o,
  output logic              r1_rsp_vld_o,
  output logic              r1_rsp_err_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  dma_state_e        state_q, state_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              arb_open;
  logic              gnt_vld;
  logic              winner;
  logic              sel_we;
  logic              sel_err;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rsp_vld;
  logic [DATA_W-1:0] rsp_data;

  // gated by reset so no grant can leak out while the block is held in reset
  assign arb_open = rst_ni && ((state_q == DMA_IDLE) || (state_q == DMA_RESP));

  dm_port_arbiter_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     ({r1_req_i, r0_req_i}),
    .open_i    (arb_open),
    .gnt_vld_o (gnt_vld),
    .winner_o  (winner)
  );

  assign sel_we    = winner ? r1_we_i    : r0_we_i;
  assign sel_addr  = winner ? r1_addr_i  : r0_addr_i;
  assign sel_wdata = winner ? r1_wdata_i : r0_wdata_i;
  // a 32-bit access must end inside the array, otherwise the byte index would wrap
  assign sel_err   = (sel_addr[DATA_W-1:MEM_BITS] != '0) ||
                     (sel_addr[MEM_BITS-1:0] > MEM_BITS'(MEM_SIZE - 4));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    case (state_q)
      DMA_IDLE, DMA_RESP: state_d = gnt_vld ? DMA_ISSUE : DMA_IDLE;
      DMA_ISSUE:          state_d = DMA_RESP;
      default:            state_d = DMA_IDLE;
    endcase
    if (gnt_vld) begin
      id_d    = winner;
      we_d    = sel_we;
      err_d   = sel_err;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      rd_en_d = !sel_we && !sel_err;
      wr_en_d = sel_we && !sel_err;
    end
  end

  assign rsp_vld  = (state_q == DMA_RESP);
  assign rsp_data = (we_q || err_q) ? '0 : mem_rdata_i;

  assign r0_gnt_o     = gnt_vld && !winner;
  assign r1_gnt_o     = gnt_vld && winner;
  assign r0_rsp_vld_o = rsp_vld && !id_q;
  assign r1_rsp_vld_o = rsp_vld && id_q;
  assign r0_rsp_err_o = r0_rsp_vld_o && err_q;
  assign r1_rsp_err_o = r1_rsp_vld_o && err_q;
  assign r0_rdata_o   = r0_rsp_vld_o ? rsp_data : rdata0_q;
  assign r1_rdata_o   = r1_rsp_vld_o ? rsp_data : rdata1_q;
  assign rdata0_d     = r0_rdata_o;
  assign rdata1_d     = r1_rdata_o;

  assign mem_rd_en_o  = rd_en_q;
  assign mem_wr_en_o  = wr_en_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = (state_q != DMA_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= DMA_IDLE;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      err_q    <= err_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: wraps a byte-addressed memory model on the port and checks
// every response against a transaction-level model (shadow memory + priority pointer).
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  localparam int DW = DM_DATA_W;
  localparam int MS = DM_MEM_SIZE;
  localparam int MB = DM_MEM_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0_req, r0_we, r1_req, r1_we;
  logic [DW-1:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic r0_gnt, r0_rsp_vld, r0_rsp_err, r1_gnt, r1_rsp_vld, r1_rsp_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic mem_rd_en, mem_wr_en, busy;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int passed = 0;

  logic [7:0] dmem   [MS];
  logic [7:0] shadow [MS];
  bit model_prio;

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
    .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
    .r0_gnt_o(r0_gnt), .r0_rsp_vld_o(r0_rsp_vld), .r0_rsp_err_o(r0_rsp_err), .r0_rdata_o(r0_rdata),
    .r1_gnt_o(r1_gnt), .r1_rsp_vld_o(r1_rsp_vld), .r1_rsp_err_o(r1_rsp_err), .r1_rdata_o(r1_rdata),
    .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  // DataMemory stand-in: registered, sign-extending 32-bit load, zero when not reading
  always @(posedge clk) begin
    int b;
    b = int'(mem_addr[MB-1:0]);
    if (mem_wr_en)
      for (int k = 0; k < 4; k++) dmem[(b + k) % MS] <= mem_wdata[8*k +: 8];
    mem_rdata <= mem_rd_en ? {{32{dmem[(b + 3) % MS][7]}}, dmem[(b + 3) % MS],
                              dmem[(b + 2) % MS], dmem[(b + 1) % MS], dmem[b]} : '0;
  end

  function automatic logic gnt_of(input int id);     return id ? r1_gnt : r0_gnt; endfunction
  function automatic logic vld_of(input int id);     return id ? r1_rsp_vld : r0_rsp_vld; endfunction
  function automatic logic err_of(input int id);     return id ? r1_rsp_err : r0_rsp_err; endfunction
  function automatic logic [DW-1:0] rd_of(input int id); return id ? r1_rdata : r0_rdata; endfunction
  function automatic logic [1:0] onehot(input int id); return (id == 1) ? 2'b10 : 2'b01; endfunction

  function automatic bit exp_err(input logic [DW-1:0] a);
    return ((a >> MB) != 0) || ((a % MS) > (MS - 4));
  endfunction

  function automatic int exp_winner(input bit q0, input bit q1);
    if (q0 && q1) return int'(model_prio);
    return q1 ? 1 : 0;
  endfunction

  task automatic model_txn(input bit we, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                           output bit err, output logic [DW-1:0] rd);
    int b;
    logic [31:0] w;
    err = exp_err(a);
    rd  = '0;
    if (!err) begin
      b = int'(a);
      if (we) begin
        for (int k = 0; k < 4; k++) shadow[b + k] = wd[8*k +: 8];
      end else begin
        w  = {shadow[b + 3], shadow[b + 2], shadow[b + 1], shadow[b]};
        rd = {{32{w[31]}}, w};
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_addr();
    int r;
    logic [DW-1:0] a;
    r = $urandom_range(0, 9);
    if (r == 0) a = DW'(MS - $urandom_range(1, 3));
    else if (r == 1) begin
      a = 1;
      a = (a << $urandom_range(MB, DW - 1)) | DW'($urandom_range(0, MS - 1));
    end else a = DW'($urandom_range(0, MS - 4));
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input int id, input bit req, input bit we,
                       input logic [DW-1:0] a, input logic [DW-1:0] wd);
    if (id == 0) begin r0_req = req; r0_we = we; r0_addr = a; r0_wdata = wd; end
    else         begin r1_req = req; r1_we = we; r1_addr = a; r1_wdata = wd; end
  endtask

  task automatic do_reset();
    set_r(0, 0, 0, '0, '0);
    set_r(1, 0, 0, '0, '0);
    rst_n = 1'b0;
    model_prio = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_txn(input int id, input bit we, input logic [DW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd_got);
    bit got;
    bit e;
    logic [DW-1:0] er;
    got = 0;
    rd_got = '0;
    set_r(id, 1, we, a, wd);
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (gnt_of(id)) got = 1;
      else tick();
    end
    checks++;
    if (!got) begin
      $display("FAIL txn_gnt r%0d: got no grant, want grant within 8 cycles", id);
      set_r(id, 0, 0, '0, '0);
      return;
    end else passed++;
    checks++;
    if (gnt_of(1 - id) !== 1'b0) $display("FAIL txn_other_gnt r%0d: got 1 want 0", 1 - id);
    else passed++;
    model_prio = (id == 0);
    model_txn(we, a, wd, e, er);
    tick();
    set_r(id, 0, we, a, wd);
    #1;
    checks++;
    if ({mem_rd_en, mem_wr_en} !== {!we && !e, we && !e})
      $display("FAIL txn_strobes r%0d: got rd=%b wr=%b want rd=%b wr=%b", id,
               mem_rd_en, mem_wr_en, !we && !e, we && !e);
    else passed++;
    checks++;
    if (mem_addr !== a || mem_wdata !== wd || vld_of(id) !== 1'b0 || busy !== 1'b1)
      $display("FAIL txn_issue r%0d: got addr=%h wdata=%h vld=%b busy=%b want addr=%h wdata=%h vld=0 busy=1",
               id, mem_addr, mem_wdata, vld_of(id), busy, a, wd);
    else passed++;
    tick();
    #1;
    checks++;
    if ({vld_of(id), err_of(id)} !== {1'b1, e})
      $display("FAIL txn_rsp r%0d: got vld=%b err=%b want vld=1 err=%b", id, vld_of(id), err_of(id), e);
    else passed++;
    checks++;
    if (rd_of(id) !== er) $display("FAIL txn_rdata r%0d: got %h want %h", id, rd_of(id), er);
    else passed++;
    rd_got = rd_of(id);
    tick();
  endtask

  task automatic contend_once(input bit we0, input logic [DW-1:0] a0, input logic [DW-1:0] wd0,
                              input bit we1, input logic [DW-1:0] a1, input logic [DW-1:0] wd1);
    int w;
    bit e;
    logic [DW-1:0] er;
    set_r(0, 1, we0, a0, wd0);
    set_r(1, 1, we1, a1, wd1);
    #1;
    w = exp_winner(1, 1);
    checks++;
    if ({r1_gnt, r0_gnt} !== onehot(w))
      $display("FAIL contend_gnt: got {r1,r0}=%b%b want %b", r1_gnt, r0_gnt, onehot(w));
    else passed++;
    model_prio = (w == 0);
    if (w == 0) model_txn(we0, a0, wd0, e, er);
    else        model_txn(we1, a1, wd1, e, er);
    tick();
    set_r(0, 0, 0, '0, '0);
    set_r(1, 0, 0, '0, '0);
    tick();
    #1;
    checks++;
    if (vld_of(w) !== 1'b1 || err_of(w) !== e || rd_of(w) !== er)
      $display("FAIL contend_rsp r%0d: got vld=%b err=%b rdata=%h want vld=1 err=%b rdata=%h",
               w, vld_of(w), err_of(w), rd_of(w), e, er);
    else passed++;
    tick();
  endtask

  // both requesters held high; a grant every other cycle, response two cycles after it
  task automatic run_both(input int ncyc, input bit rnd);
    bit we_c [2];
    logic [DW-1:0] a_c [2];
    logic [DW-1:0] wd_c [2];
    int pend_id;
    int w;
    bit pend_e;
    logic [DW-1:0] pend_rd;
    pend_id = -1;
    pend_e = 0;
    pend_rd = '0;
    w = 0;
    for (int i = 0; i < 2; i++) begin
      we_c[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      a_c[i]  = rnd ? rand_addr() : DW'(16 + 84 * i);
      wd_c[i] = {$urandom, $urandom};
      set_r(i, 1, we_c[i], a_c[i], wd_c[i]);
    end
    for (int k = 0; k < ncyc; k++) begin
      #1;
      checks++;
      if (r0_gnt && r1_gnt) $display("FAIL both_gnt cyc%0d: got 11 want one-hot", k);
      else passed++;
      if (k > 0) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL stream_busy cyc%0d: got %b want 1", k, busy);
        else passed++;
      end
      if (k % 2 == 0) begin
        if (pend_id >= 0) begin
          checks++;
          if (vld_of(pend_id) !== 1'b1 || err_of(pend_id) !== pend_e || rd_of(pend_id) !== pend_rd)
            $display("FAIL stream_rsp cyc%0d r%0d: got vld=%b err=%b rdata=%h want vld=1 err=%b rdata=%h",
                     k, pend_id, vld_of(pend_id), err_of(pend_id), rd_of(pend_id), pend_e, pend_rd);
          else passed++;
        end
        w = exp_winner(1, 1);
        checks++;
        if ({r1_gnt, r0_gnt} !== onehot(w))
          $display("FAIL stream_gnt cyc%0d: got {r1,r0}=%b%b want %b", k, r1_gnt, r0_gnt, onehot(w));
        else passed++;
        model_prio = (w == 0);
        model_txn(we_c[w], a_c[w], wd_c[w], pend_e, pend_rd);
        pend_id = w;
      end else begin
        checks++;
        if ({r1_gnt, r0_gnt, r1_rsp_vld, r0_rsp_vld} !== 4'b0)
          $display("FAIL stream_quiet cyc%0d: got gnt=%b%b vld=%b%b want 0000", k,
                   r1_gnt, r0_gnt, r1_rsp_vld, r0_rsp_vld);
        else passed++;
      end
      tick();
      if (k % 2 == 0 && rnd) begin
        we_c[w] = 1'($urandom_range(0, 1));
        a_c[w]  = rand_addr();
        wd_c[w] = {$urandom, $urandom};
        set_r(w, 1, we_c[w], a_c[w], wd_c[w]);
      end
    end
    set_r(0, 0, 0, '0, '0);
    set_r(1, 0, 0, '0, '0);
    #1;
    checks++;
    if (pend_id < 0 || vld_of(pend_id) !== 1'b1 || err_of(pend_id) !== pend_e || rd_of(pend_id) !== pend_rd)
      $display("FAIL stream_last_rsp r%0d: got vld=%b err=%b rdata=%h want vld=1 err=%b rdata=%h",
               pend_id, vld_of(pend_id), err_of(pend_id), rd_of(pend_id), pend_e, pend_rd);
    else passed++;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_prio = 1'b0;
    set_r(0, 1, 0, DW'(16), '0);
    set_r(1, 1, 1, DW'(8), DW'(5));
    tick(); tick();
    #1;
    checks++;
    if ({r0_gnt, r1_gnt, r0_rsp_vld, r1_rsp_vld, r0_rsp_err, r1_rsp_err, mem_rd_en, mem_wr_en, busy} !== 9'b0)
      $display("FAIL reset_ctrl: got %b want 000000000",
               {r0_gnt, r1_gnt, r0_rsp_vld, r1_rsp_vld, r0_rsp_err, r1_rsp_err, mem_rd_en, mem_wr_en, busy});
    else passed++;
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || r0_rdata !== '0 || r1_rdata !== '0)
      $display("FAIL reset_data: got addr=%h wdata=%h rd0=%h rd1=%h want all 0",
               mem_addr, mem_wdata, r0_rdata, r1_rdata);
    else passed++;
    set_r(0, 0, 0, '0, '0);
    set_r(1, 0, 0, '0, '0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    logic [DW-1:0] rd;
    do_txn(0, 1, DW'(16), 64'h0000_0000_8000_00FF, rd);
    do_txn(0, 0, DW'(16), '0, rd);
    checks++;
    if (rd !== 64'hFFFF_FFFF_8000_00FF) $display("FAIL sext_load: got %h want ffffffff800000ff", rd);
    else passed++;
  endtask

  task automatic test_range();
    logic [DW-1:0] rd;
    do_txn(1, 0, DW'(MS - 3), '0, rd);
    do_txn(1, 0, DW'(MS - 4), '0, rd);
    do_txn(1, 1, DW'(MS - 1), 64'h1234, rd);
  endtask

  task automatic test_err_prio();
    logic [DW-1:0] a;
    logic [DW-1:0] rd;
    a = 1;
    a = (a << MB) + 8;
    do_txn(0, 0, a, '0, rd);
    contend_once(0, DW'(16), '0, 0, DW'(MS - 4), '0);
  endtask

  task automatic test_random_serial();
    logic [DW-1:0] rd;
    for (int i = 0; i < 16; i++)
      do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom}, rd);
  endtask

  task automatic test_withdraw();
    logic [DW-1:0] rd;
    bit e;
    logic [DW-1:0] er;
    set_r(0, 1, 0, DW'(40), '0);
    #1;
    checks++;
    if (r0_gnt !== 1'b1) $display("FAIL withdraw_r0_gnt: got %b want 1", r0_gnt);
    else passed++;
    model_prio = 1'b1;
    model_txn(0, DW'(40), '0, e, er);
    tick();
    set_r(0, 0, 0, '0, '0);
    set_r(1, 1, 1, DW'(48), 64'hDEAD_BEEF_CAFE_F00D);
    #1;
    checks++;
    if (r1_gnt !== 1'b0) $display("FAIL withdraw_issue_gnt: got %b want 0", r1_gnt);
    else passed++;
    tick();
    set_r(1, 0, 0, '0, '0);
    #1;
    checks++;
    if (r1_gnt !== 1'b0 || r0_rsp_vld !== 1'b1 || r0_rdata !== er)
      $display("FAIL withdraw_resp: got r1_gnt=%b r0_vld=%b rdata=%h want 0 1 %h", r1_gnt, r0_rsp_vld, r0_rdata, er);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      checks++;
      if (r1_gnt !== 1'b0 || busy !== 1'b0 || mem_wr_en !== 1'b0)
        $display("FAIL withdraw_idle cyc%0d: got gnt=%b busy=%b wr=%b want 000", k, r1_gnt, busy, mem_wr_en);
      else passed++;
    end
    tick();
    do_txn(0, 0, DW'(48), '0, rd);
  endtask

  task automatic test_reset_midflight();
    set_r(0, 1, 1, DW'(32), 64'h0000_0000_5A5A_A5A5);
    #1;
    checks++;
    if (r0_gnt !== 1'b1) $display("FAIL rstmid_gnt: got %b want 1", r0_gnt);
    else passed++;
    tick();
    set_r(0, 0, 0, '0, '0);
    #1;
    checks++;
    if (mem_wr_en !== 1'b1) $display("FAIL rstmid_issue: got wr=%b want 1", mem_wr_en);
    else passed++;
    rst_n = 1'b0;
    model_prio = 1'b0;
    #1;
    checks++;
    if ({r0_gnt, r1_gnt, r0_rsp_vld, r1_rsp_vld, mem_rd_en, mem_wr_en, busy} !== 7'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || r0_rdata !== '0 || r1_rdata !== '0)
      $display("FAIL rstmid_outputs: got ctrl=%b addr=%h wdata=%h want all 0",
               {r0_gnt, r1_gnt, r0_rsp_vld, r1_rsp_vld, mem_rd_en, mem_wr_en, busy}, mem_addr, mem_wdata);
    else passed++;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({r0_rsp_vld, r1_rsp_vld, busy} !== 3'b0)
        $display("FAIL rstmid_norsp cyc%0d: got vld=%b%b busy=%b want 000", k, r1_rsp_vld, r0_rsp_vld, busy);
      else passed++;
      tick();
    end
    contend_once(0, DW'(32), '0, 0, DW'(16), '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MS; i++) begin
      dmem[i]   = 8'h00;
      shadow[i] = 8'h00;
    end
    set_r(0, 0, 0, '0, '0);
    set_r(1, 0, 0, '0, '0);
    model_prio = 1'b0;
    test_reset();
    test_store_load();
    do_reset();
    run_both(6, 1'b0);
    test_range();
    test_err_prio();
    run_both(40, 1'b1);
    test_random_serial();
    test_withdraw();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
